draw_sprites: RTL and testbench



---
 rtl/draw_sprites.sv | 180 ++++++++++++++++++
 tb/tb_draw_sprites.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_sprites.sv
// Multi-sprite overlay stage: composites N_SPRITES rotatable, colour-keyed sprites over the background with a fixed 2-cycle latency.
// Optional feature macro: DRAW_SPRITES_COLLISION_EN adds per-frame sticky collision flags.
module draw_sprites #(
  parameter int          N_SPRITES = 2,
  parameter int          WIDTH     = 64,
  parameter int          HEIGHT    = 64,
  parameter int          ADDR_W    = 12,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input  logic                          pclk,
  input  logic                          rst,
  input  logic [10:0]                   hcount_in,
  input  logic [10:0]                   vcount_in,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic                          hblnk_in,
  input  logic                          vblnk_in,
  input  logic [11:0]                   rgb_in,
  input  logic [11*N_SPRITES-1:0]       xpos,
  input  logic [11*N_SPRITES-1:0]       ypos,
  input  logic [2*N_SPRITES-1:0]        rotation,
  input  logic [N_SPRITES-1:0]          visible,
  output logic [ADDR_W*N_SPRITES-1:0]   pixel_addr,
  input  logic [12*N_SPRITES-1:0]       rgb_pixel,
  output logic [10:0]                   hcount_out,
  output logic [10:0]                   vcount_out,
  output logic                          hsync_out,
  output logic                          vsync_out,
  output logic                          hblnk_out,
  output logic                          vblnk_out,
  output logic [11:0]                   rgb_out
`ifdef DRAW_SPRITES_COLLISION_EN
  ,
  output logic [N_SPRITES-1:0]          collision,
  output logic                          collision_valid
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  logic                        frame_start;
  logic [11*N_SPRITES-1:0]     sh_xpos, sh_ypos, cur_xpos, cur_ypos;
  logic [2*N_SPRITES-1:0]      sh_rot, cur_rot;
  logic [N_SPRITES-1:0]        sh_vis, cur_vis;
  logic [N_SPRITES-1:0]        hit_c, hit_s1, opaque;
  logic [ADDR_W*N_SPRITES-1:0] addr_c;
  logic [10:0]                 hcount_s1, vcount_s1;
  logic                        hsync_s1, vsync_s1, hblnk_s1, vblnk_s1;
  logic [11:0]                 rgb_s1, pix_c;
  logic [11:0]                 h12, v12;

  // Shadows load at frame start; the hit test of that same pixel already sees the new values.
  assign frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);
  assign cur_xpos    = frame_start ? xpos     : sh_xpos;
  assign cur_ypos    = frame_start ? ypos     : sh_ypos;
  assign cur_rot     = frame_start ? rotation : sh_rot;
  assign cur_vis     = frame_start ? visible  : sh_vis;
  assign h12         = {1'b0, hcount_in};
  assign v12         = {1'b0, vcount_in};

  for (genvar i = 0; i < N_SPRITES; i++) begin : g_spr
    logic [11:0]   x12, y12;
    logic [CW-1:0] c, nc, col;
    logic [RW-1:0] r, nr, row;

    assign x12 = {1'b0, cur_xpos[11*i +: 11]};
    assign y12 = {1'b0, cur_ypos[11*i +: 11]};
    assign c   = hcount_in[CW-1:0] - cur_xpos[11*i +: CW];
    assign r   = vcount_in[RW-1:0] - cur_ypos[11*i +: RW];
    assign nc  = ~c;
    assign nr  = ~r;

    // 12-bit compare so sprites past the right/bottom edge clip instead of wrapping.
    assign hit_c[i] = cur_vis[i] &&
                      (h12 >= x12) && (h12 < x12 + 12'(WIDTH)) &&
                      (v12 >= y12) && (v12 < y12 + 12'(HEIGHT));

    always_comb begin
      row = r;
      col = c;
      case (cur_rot[2*i +: 2])
        2'd1: begin row = RW'(nc); col = CW'(r);  end
        2'd2: begin row = nr;      col = nc;      end
        2'd3: begin row = RW'(c);  col = CW'(nr); end
        default: ;
      endcase
    end

    assign addr_c[ADDR_W*i +: ADDR_W] = hit_c[i] ? ADDR_W'({row, col}) : '0;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      sh_xpos    <= '0;
      sh_ypos    <= '0;
      sh_rot     <= '0;
      sh_vis     <= '0;
      hit_s1     <= '0;
      pixel_addr <= '0;
      hcount_s1  <= '0;
      vcount_s1  <= '0;
      hsync_s1   <= 1'b0;
      vsync_s1   <= 1'b0;
      hblnk_s1   <= 1'b0;
      vblnk_s1   <= 1'b0;
      rgb_s1     <= '0;
    end else begin
      if (frame_start) begin
        sh_xpos <= xpos;
        sh_ypos <= ypos;
        sh_rot  <= rotation;
        sh_vis  <= visible;
      end
      hit_s1     <= hit_c;
      pixel_addr <= addr_c;
      hcount_s1  <= hcount_in;
      vcount_s1  <= vcount_in;
      hsync_s1   <= hsync_in;
      vsync_s1   <= vsync_in;
      hblnk_s1   <= hblnk_in;
      vblnk_s1   <= vblnk_in;
      rgb_s1     <= rgb_in;
    end
  end

  // Walk from the highest index down so the lowest-index opaque sprite ends up on top.
  always_comb begin
    opaque = '0;
    pix_c  = rgb_s1;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      opaque[i] = hit_s1[i] && (rgb_pixel[12*i +: 12] != KEY_COLOR);
      if (opaque[i]) pix_c = rgb_pixel[12*i +: 12];
    end
    if (hblnk_s1 || vblnk_s1) pix_c = 12'h000;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_s1;
      vcount_out <= vcount_s1;
      hsync_out  <= hsync_s1;
      vsync_out  <= vsync_s1;
      hblnk_out  <= hblnk_s1;
      vblnk_out  <= vblnk_s1;
      rgb_out    <= pix_c;
    end
  end

`ifdef DRAW_SPRITES_COLLISION_EN
  logic [N_SPRITES-1:0] col_acc, col_hits;

  assign col_hits = (($countones(opaque) > 1) && !(hblnk_s1 || vblnk_s1)) ? opaque : '0;

  // The frame-start pixel already belongs to the new frame, so it seeds the fresh accumulator.
  always_ff @(posedge pclk) begin
    if (rst) begin
      col_acc         <= '0;
      collision       <= '0;
      collision_valid <= 1'b0;
    end else if ((hcount_s1 == 11'd0) && (vcount_s1 == 11'd0)) begin
      collision       <= col_acc;
      col_acc         <= col_hits;
      collision_valid <= 1'b1;
    end else begin
      col_acc         <= col_acc | col_hits;
      collision_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_draw_sprites.sv
// Directed bench for draw_sprites: behavioural sprite model feeds an expected queue compared at the pipeline output.
module tb_draw_sprites;
  localparam int N = 2;

  logic          pclk = 1'b0;
  logic          rst;
  logic [10:0]   hcount_in, vcount_in;
  logic          hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0]   rgb_in;
  logic [11*N-1:0] xpos, ypos;
  logic [2*N-1:0]  rotation;
  logic [N-1:0]    visible;
  logic [12*N-1:0] pixel_addr;
  logic [12*N-1:0] rgb_pixel;
  logic [10:0]   hcount_out, vcount_out;
  logic          hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0]   rgb_out;
`ifdef DRAW_SPRITES_COLLISION_EN
  logic [N-1:0]  collision;
  logic          collision_valid;
`endif

  int          total = 0;
  int          bad   = 0;
  logic [37:0] exp_q[$];
  int          sh_x[N], sh_y[N], sh_rot[N];
  bit          sh_vis[N];
  int          rom_mode[N];
  logic [11:0] rom_col[N];
  int          rexp[4];

  always #5 pclk = ~pclk;

  draw_sprites #(.N_SPRITES(N)) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .rotation(rotation), .visible(visible),
    .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
`ifdef DRAW_SPRITES_COLLISION_EN
    , .collision(collision), .collision_valid(collision_valid)
`endif
  );

  // ROM model: address register lives in the DUT, data follows one cycle after the address is computed.
  always_comb begin
    rgb_pixel = '0;
    for (int i = 0; i < N; i++)
      rgb_pixel[12*i +: 12] = (rom_mode[i] == 0) ? pixel_addr[12*i +: 12] : rom_col[i];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_spr(input int i, input int x, input int y, input int rot, input bit vis);
    xpos[11*i +: 11]   = 11'(x);
    ypos[11*i +: 11]   = 11'(y);
    rotation[2*i +: 2] = 2'(rot);
    visible[i]         = vis;
  endtask

  function automatic logic [11:0] rom_model(input int i, input int addr);
    return (rom_mode[i] == 0) ? 12'(addr) : rom_col[i];
  endfunction

  task automatic step(input int h, input int v, input bit hb, input bit vb, input logic [11:0] bg);
    logic [11:0]   exp_rgb;
    logic [12*N-1:0] exp_addr;
    logic [37:0]   item;
    logic          hs, vs;
    int            c, r, row, col, a;
    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
    if (h == 0 && v == 0)
      for (int i = 0; i < N; i++) begin
        sh_x[i]   = int'(xpos[11*i +: 11]);
        sh_y[i]   = int'(ypos[11*i +: 11]);
        sh_rot[i] = int'(rotation[2*i +: 2]);
        sh_vis[i] = visible[i];
      end
    exp_rgb  = bg;
    exp_addr = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (sh_vis[i] && h >= sh_x[i] && h < sh_x[i] + 64 && v >= sh_y[i] && v < sh_y[i] + 64) begin
        c = (h - sh_x[i]) & 63;
        r = (v - sh_y[i]) & 63;
        case (sh_rot[i])
          1:       begin row = 63 - c; col = r;      end
          2:       begin row = 63 - r; col = 63 - c; end
          3:       begin row = c;      col = 63 - r; end
          default: begin row = r;      col = c;      end
        endcase
        a = row * 64 + col;
        exp_addr[12*i +: 12] = 12'(a);
        if (rom_model(i, a) != 12'hF0F) exp_rgb = rom_model(i, a);
      end
    end
    if (hb || vb) exp_rgb = 12'h000;
    exp_q.push_back({11'(h), 11'(v), hs, vs, hb, vb, exp_rgb});
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in  = hs;
    vsync_in  = vs;
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = bg;
    @(posedge pclk);
    #1;
    check("pixel_addr", 64'(pixel_addr), 64'(exp_addr));
    if (exp_q.size() == 2) begin
      item = exp_q.pop_front();
      check("rgb_out", 64'(rgb_out), 64'(item[11:0]));
      check("timing_out", 64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
            64'(item[37:12]));
    end
  endtask

  task automatic idle();
    step(1500, 700, 1'b1, 1'b1, 12'h000);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge pclk);
    #1;
    check({tag, "_rgb"}, 64'(rgb_out), 64'd0);
    check({tag, "_addr"}, 64'(pixel_addr), 64'd0);
    check({tag, "_timing"}, 64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 64'd0);
`ifdef DRAW_SPRITES_COLLISION_EN
    check({tag, "_coll"}, 64'({collision, collision_valid}), 64'd0);
`endif
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_rot[i] = 0; sh_vis[i] = 1'b0;
    end
    exp_q.delete();
  endtask

  initial begin
    rexp = '{131, 3842, 3964, 253};
    rst = 1'b1;
    hcount_in = 11'd1500; vcount_in = 11'd700;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b1; vblnk_in = 1'b1;
    rgb_in = 12'h000; xpos = '0; ypos = '0; rotation = '0; visible = '0;
    for (int i = 0; i < N; i++) begin rom_mode[i] = 0; rom_col[i] = 12'h000; end
    repeat (2) @(posedge pclk);
    #1;
    do_reset("reset");

    // single sprite, all four rotations at the same screen point
    set_spr(0, 100, 50, 0, 1'b1);
    set_spr(1, 600, 600, 0, 1'b0);
    for (int rt = 0; rt < 4; rt++) begin
      rotation[1:0] = 2'(rt);
      step(0, 0, 1'b0, 1'b0, 12'h321);
      step(103, 52, 1'b0, 1'b0, 12'h456);
      check("rot_addr", 64'(pixel_addr[11:0]), 64'(rexp[rt]));
      idle();
      check("rot_rgb", 64'(rgb_out), 64'(rexp[rt]));
    end
    // corners and just-outside pixels of the rot-0 sprite
    rotation[1:0] = 2'd0;
    step(0, 0, 1'b0, 1'b0, 12'h111);
    step(100, 50, 1'b0, 1'b0, 12'h222);
    step(163, 113, 1'b0, 1'b0, 12'h333);
    step(164, 52, 1'b0, 1'b0, 12'h444);
    step(99, 52, 1'b0, 1'b0, 12'h555);
    step(103, 114, 1'b0, 1'b0, 12'h666);
    idle();

    // priority and colour key
    set_spr(0, 200, 200, 0, 1'b1);
    set_spr(1, 200, 200, 0, 1'b1);
    rom_mode[0] = 1; rom_mode[1] = 1;
    rom_col[0] = 12'h00F; rom_col[1] = 12'h0F0;
    step(0, 0, 1'b0, 1'b0, 12'h123);
    step(210, 205, 1'b0, 1'b0, 12'h123);
    idle();
    check("prio_top", 64'(rgb_out), 64'h00F);
    rom_col[0] = 12'hF0F;
    step(210, 205, 1'b0, 1'b0, 12'h123);
    idle();
    check("prio_key0", 64'(rgb_out), 64'h0F0);
    rom_col[1] = 12'hF0F;
    step(210, 205, 1'b0, 1'b0, 12'h123);
    idle();
    check("prio_bg", 64'(rgb_out), 64'h123);

    // position changes take effect only at the next frame start
    rom_mode[0] = 0; rom_mode[1] = 0;
    set_spr(0, 100, 380, 0, 1'b1);
    set_spr(1, 600, 600, 0, 1'b0);
    step(0, 0, 1'b0, 1'b0, 12'h000);
    step(110, 400, 1'b0, 1'b0, 12'hABC);
    xpos[10:0] = 11'd300;
    step(110, 401, 1'b0, 1'b0, 12'hABC);
    step(310, 401, 1'b0, 1'b0, 12'hABC);
    idle();
    check("latch_old_frame", 64'(rgb_out), 64'hABC);
    step(0, 0, 1'b0, 1'b0, 12'h000);
    step(310, 401, 1'b0, 1'b0, 12'hABC);
    step(110, 401, 1'b0, 1'b0, 12'hABC);
    idle();
    check("latch_new_frame", 64'(rgb_out), 64'hABC);

    // right-edge clipping and blanking
    set_spr(0, 1000, 10, 0, 1'b1);
    step(0, 0, 1'b0, 1'b0, 12'h000);
    step(999, 20, 1'b0, 1'b0, 12'h777);
    step(1000, 20, 1'b0, 1'b0, 12'h777);
    step(1023, 20, 1'b0, 1'b0, 12'h777);
    step(1024, 20, 1'b1, 1'b0, 12'h777);
    step(1040, 20, 1'b1, 1'b0, 12'h777);
    step(1010, 30, 1'b0, 1'b1, 12'h777);
    for (int k = 0; k < 40; k++)
      step($urandom_range(990, 1030), $urandom_range(0, 80), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 12'($urandom_range(0, 4095)));
    idle();

    // reset mid-frame clears everything; nothing is drawn until a frame start
    step(1010, 20, 1'b0, 1'b0, 12'h888);
    do_reset("mid_reset");
    step(1010, 20, 1'b0, 1'b0, 12'h888);
    step(1011, 21, 1'b0, 1'b0, 12'h888);
    step(0, 0, 1'b0, 1'b0, 12'h000);
    step(1011, 21, 1'b0, 1'b0, 12'h888);
    idle();
    idle();

`ifdef DRAW_SPRITES_COLLISION_EN
    rom_mode[0] = 1; rom_mode[1] = 1;
    rom_col[0] = 12'h00F; rom_col[1] = 12'h0F0;
    set_spr(0, 200, 200, 0, 1'b1);
    set_spr(1, 200, 200, 0, 1'b1);
    step(0, 0, 1'b0, 1'b0, 12'h000);
    step(210, 205, 1'b0, 1'b0, 12'h000);
    idle();
    set_spr(1, 400, 400, 0, 1'b1);
    step(0, 0, 1'b0, 1'b0, 12'h000);
    step(5, 5, 1'b0, 1'b0, 12'h000);
    check("coll_valid", 64'(collision_valid), 64'd1);
    check("coll_overlap", 64'(collision), 64'h3);
    step(210, 205, 1'b0, 1'b0, 12'h000);
    check("coll_valid_low", 64'(collision_valid), 64'd0);
    idle();
    step(0, 0, 1'b0, 1'b0, 12'h000);
    step(5, 5, 1'b0, 1'b0, 12'h000);
    check("coll_valid2", 64'(collision_valid), 64'd1);
    check("coll_clear", 64'(collision), 64'h0);
    idle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
